// File: rtl/reg_bus_pkg.sv
// Shared constants and types for the register-bus slave.
// Address map: 0x00 ID, 0x01-0xFC storage, 0xFD ACC, 0xFE WCNT, 0xFF LAST.
package reg_bus_pkg;

    localparam logic [15:0] ID_VALUE  = 16'hA5C3;

    localparam logic [7:0]  ADDR_ID   = 8'h00;
    localparam logic [7:0]  ADDR_ACC  = 8'hFD;
    localparam logic [7:0]  ADDR_WCNT = 8'hFE;
    localparam logic [7:0]  ADDR_LAST = 8'hFF;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bus_store.sv
// Register-bus backing store: single write port, one asynchronous read port.
// Contents are never reset; the slave clears them with its INIT sweep.
module reg_bus_store #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_bus_slave.sv
// Register-bus slave: post-reset clear sweep, then write-first register
// access with ID, accumulator, write counter and last-address registers.
module reg_bus_slave
    import reg_bus_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] address,
    output logic [DW-1:0] data_out,
    output logic          init_done
);

    state_t        state_reg, state_next;
    logic [AW-1:0] init_cnt_reg, init_cnt_next;
    logic [DW-1:0] acc_reg, acc_next;
    logic [DW-1:0] wcnt_reg, wcnt_next;
    logic [DW-1:0] last_reg, last_next;
    logic [DW-1:0] data_out_reg, data_out_next;

    logic          store_we;
    logic [AW-1:0] store_waddr;
    logic [DW-1:0] store_wdata;
    logic [DW-1:0] store_rdata;
    logic [DW-1:0] acc_sum;

    assign acc_sum = acc_reg + data_in;

    // A write sampled on a reset edge must never reach the storage array.
    reg_bus_store #(
        .DW(DW),
        .AW(AW)
    ) u_store (
        .clk   (clk),
        .we    (store_we & rst_n),
        .waddr (store_waddr),
        .wdata (store_wdata),
        .raddr (address),
        .rdata (store_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
            acc_reg      <= '0;
            wcnt_reg     <= '0;
            last_reg     <= '0;
            data_out_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            acc_reg      <= acc_next;
            wcnt_reg     <= wcnt_next;
            last_reg     <= last_next;
            data_out_reg <= data_out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        acc_next      = acc_reg;
        wcnt_next     = wcnt_reg;
        last_next     = last_reg;
        data_out_next = '0;
        store_we      = 1'b0;
        store_waddr   = address;
        store_wdata   = data_in;

        case (state_reg)
            INIT: begin
                store_we      = 1'b1;
                store_waddr   = init_cnt_reg;
                store_wdata   = '0;
                init_cnt_next = init_cnt_reg + AW'(1);
                if (init_cnt_reg == '1) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                // Read and write share one address, so the read returns the
                // post-write value of whatever this edge writes.
                if (address == AW'(ADDR_ID)) begin
                    data_out_next = DW'(ID_VALUE);
                end else if (address == AW'(ADDR_LAST)) begin
                    data_out_next = last_reg;
                end else if (address == AW'(ADDR_WCNT)) begin
                    data_out_next = write ? '0 : wcnt_reg;
                    if (write) begin
                        wcnt_next = '0;
                        last_next = DW'(address);
                    end
                end else if (address == AW'(ADDR_ACC)) begin
                    data_out_next = write ? acc_sum : acc_reg;
                    if (write) begin
                        acc_next  = acc_sum;
                        wcnt_next = wcnt_reg + DW'(1);
                        last_next = DW'(address);
                    end
                end else begin
                    data_out_next = write ? data_in : store_rdata;
                    if (write) begin
                        store_we  = 1'b1;
                        wcnt_next = wcnt_reg + DW'(1);
                        last_next = DW'(address);
                    end
                end
            end

            default: state_next = INIT;
        endcase
    end

    assign data_out  = data_out_reg;
    assign init_done = (state_reg == RUN);

endmodule

// File: tb/tb_reg_bus_slave.sv
// Self-checking bench for reg_bus_slave: directed scenarios plus random
// traffic, checked against a simple apply-write-then-read register model.
module tb_reg_bus_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [15:0] data_in = '0;
    logic [7:0]  address = '0;
    logic [15:0] data_out;
    logic        init_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [15:0] m_mem [0:255];
    logic [15:0] m_acc, m_wcnt, m_last;

    reg_bus_slave #(.DW(16), .AW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .write     (write),
        .data_in   (data_in),
        .address   (address),
        .data_out  (data_out),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_acc  = '0;
        m_wcnt = '0;
        m_last = '0;
    endtask

    task automatic model_access(input bit w, input logic [7:0] a, input logic [15:0] d,
                                output logic [15:0] exp);
        if (w && a != 8'h00 && a != 8'hFF) begin
            if (a == 8'hFE) begin
                m_wcnt = '0;
            end else begin
                m_wcnt = m_wcnt + 16'd1;
                if (a == 8'hFD) m_acc = m_acc + d;
                else            m_mem[a] = d;
            end
            m_last = {8'h00, a};
        end
        case (a)
            8'h00:   exp = 16'hA5C3;
            8'hFD:   exp = m_acc;
            8'hFE:   exp = m_wcnt;
            8'hFF:   exp = m_last;
            default: exp = m_mem[a];
        endcase
    endtask

    task automatic access(input bit w, input logic [7:0] a, input logic [15:0] d, input string tag);
        logic [15:0] exp;
        write   = w;
        address = a;
        data_in = d;
        model_access(w, a, d, exp);
        @(posedge clk); #1;
        $display("txn %s w=%0b a=%h d=%h dout=%h", tag, w, a, d, data_out);
        check(tag, {16'h0, data_out}, {16'h0, exp});
        write = 1'b0;
    endtask

    // Counts edges from reset release until init_done, optionally injecting
    // a write on a given INIT cycle.
    task automatic wait_init(input int inject_cyc, input string tag);
        int cyc = 0;
        while (!init_done && cyc < 300) begin
            write   = (cyc + 1 == inject_cyc);
            address = 8'h05;
            data_in = 16'hBEEF;
            @(posedge clk); #1;
            cyc++;
            if (!init_done) check({tag, "_dout_init"}, {16'h0, data_out}, 32'h0);
        end
        write = 1'b0;
        $display("txn %s init_done after %0d cycles", tag, cyc);
        check({tag, "_init_len"}, cyc, 256);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [15:0] rd;
        bit          rw;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_dout", {16'h0, data_out}, 32'h0);

        // Clear sequence, with a write dropped on INIT cycle 10
        rst_n = 1'b1;
        wait_init(10, "boot");
        model_reset();
        access(0, 8'h05, 16'h0, "init_drop_05");
        access(0, 8'hFE, 16'h0, "init_drop_wcnt");

        // Storage write/read
        access(1, 8'h10, 16'h1234, "st_wr_10");
        access(0, 8'h10, 16'h0, "st_rd_10");
        access(0, 8'hFE, 16'h0, "st_wcnt");

        // ID register
        access(0, 8'h00, 16'h0, "id_rd");
        access(1, 8'h00, 16'hFFFF, "id_wr");
        access(0, 8'h00, 16'h0, "id_rd2");
        access(0, 8'hFE, 16'h0, "id_wcnt");
        access(0, 8'hFF, 16'h0, "id_last");

        // LAST is read-only
        access(1, 8'hFF, 16'h7777, "last_wr");
        access(0, 8'hFE, 16'h0, "last_wr_wcnt");

        // WCNT clear then ACC wrap
        access(1, 8'hFE, 16'h9999, "wcnt_clr");
        access(1, 8'hFD, 16'hFFFF, "acc_wr1");
        access(1, 8'hFD, 16'h0002, "acc_wr2");
        access(0, 8'hFD, 16'h0, "acc_rd");
        access(0, 8'hFE, 16'h0, "acc_wcnt");
        access(0, 8'hFF, 16'h0, "acc_last");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rw = ($urandom_range(0, 1) == 1);
            rd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       ra = 8'h00;
                    1:       ra = 8'hFD;
                    2:       ra = 8'hFE;
                    default: ra = 8'hFF;
                endcase
            end else begin
                ra = 8'($urandom_range(0, 255));
            end
            access(rw, ra, rd, "rand");
        end

        // Reset mid-RUN, with a write on the reset edge that must be dropped
        access(1, 8'h20, 16'h5555, "rr_wr_20");
        rst_n   = 1'b0;
        write   = 1'b1;
        address = 8'h30;
        data_in = 16'h7777;
        @(posedge clk); #1;
        check("rr_init_done", {31'h0, init_done}, 32'h0);
        check("rr_dout", {16'h0, data_out}, 32'h0);
        rst_n = 1'b1;
        wait_init(0, "rerun");
        model_reset();
        access(0, 8'h20, 16'h0, "rr_rd_20");
        access(0, 8'hFF, 16'h0, "rr_last");
        access(0, 8'h30, 16'h0, "rr_rd_30");
        access(0, 8'hFE, 16'h0, "rr_wcnt");
        access(0, 8'hFD, 16'h0, "rr_acc");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
